// File: rtl/fpga_ram_be_init.sv
// Single-port block RAM with per-lane write enables and a power-up/reset sweep
// that loads INITVALUE into every word before accesses are accepted.
module fpga_ram_be_init #(
    parameter int unsigned          DATAWIDTH = 32,
    parameter int unsigned          ADDRWIDTH = 10,
    parameter int unsigned          BYTEWIDTH = 8,
    parameter int unsigned          WRITEMODE = 0,
    parameter int unsigned          OUTREG    = 0,
    parameter logic [DATAWIDTH-1:0] INITVALUE = {DATAWIDTH{1'b0}}
) (
    input  logic                           PortAClk,
    input  logic                           PortARst,
    input  logic                           PortAChipEnable,
    input  logic [ADDRWIDTH-1:0]           PortAAddr,
    input  logic [DATAWIDTH-1:0]           PortADataIn,
    input  logic [DATAWIDTH/BYTEWIDTH-1:0] PortAWriteEnable,
    output logic [DATAWIDTH-1:0]           PortADataOut,
    output logic                           PortADataValid,
    output logic                           InitBusy
);

    localparam int unsigned NBYTES   = DATAWIDTH / BYTEWIDTH;
    localparam int unsigned MEMDEPTH = 2 ** ADDRWIDTH;
    localparam logic [ADDRWIDTH-1:0] SWEEP_LAST = {ADDRWIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDRWIDTH-1:0]   sweep_q, sweep_d;
    logic                   init_busy_q, init_busy_d;

    logic [DATAWIDTH-1:0]   mem_q [MEMDEPTH];

    logic [NBYTES-1:0]      wr_lane_s;
    logic [ADDRWIDTH-1:0]   wr_addr_s;
    logic [DATAWIDTH-1:0]   wr_data_s;
    logic                   access_s;
    logic                   is_write_s;
    logic                   fire_s;

    logic [DATAWIDTH-1:0]   dout1_q;
    logic                   valid1_q;

    // Overlay the enabled lanes of new_word onto old_word.
    function automatic logic [DATAWIDTH-1:0] lane_merge(
        input logic [DATAWIDTH-1:0] old_word,
        input logic [DATAWIDTH-1:0] new_word,
        input logic [NBYTES-1:0]    lane_en
    );
        logic [DATAWIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < NBYTES; i++) begin
            if (lane_en[i]) begin
                res[i*BYTEWIDTH +: BYTEWIDTH] = new_word[i*BYTEWIDTH +: BYTEWIDTH];
            end else begin
                res[i*BYTEWIDTH +: BYTEWIDTH] = old_word[i*BYTEWIDTH +: BYTEWIDTH];
            end
        end
        return res;
    endfunction

    // FSM state, sweep counter and busy flag registers.
    always_ff @(posedge PortAClk) begin
        if (PortARst) begin
            state_q     <= ST_INIT;
            sweep_q     <= {ADDRWIDTH{1'b0}};
            init_busy_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            init_busy_q <= init_busy_d;
        end
    end

    // Next-state logic: sweep every address once, then stay READY until reset.
    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == SWEEP_LAST) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_READY: begin
                state_d = ST_READY;
                sweep_d = sweep_q;
            end
            default: begin
                state_d = ST_INIT;
                sweep_d = {ADDRWIDTH{1'b0}};
            end
        endcase
        init_busy_d = (state_d == ST_INIT);
    end

    // Accesses are honoured only in READY and never alongside reset.
    assign access_s   = (state_q == ST_READY) && PortAChipEnable && !PortARst;
    assign is_write_s = |PortAWriteEnable;
    assign fire_s     = access_s && (!is_write_s || (WRITEMODE != 32'd2));

    // Single write port shared between the init sweep and user writes.
    always_comb begin
        wr_lane_s = {NBYTES{1'b0}};
        wr_addr_s = PortAAddr;
        wr_data_s = PortADataIn;
        if (PortARst) begin
            wr_lane_s = {NBYTES{1'b0}};
        end else if (state_q == ST_INIT) begin
            wr_lane_s = {NBYTES{1'b1}};
            wr_addr_s = sweep_q;
            wr_data_s = INITVALUE;
        end else if (PortAChipEnable) begin
            wr_lane_s = PortAWriteEnable;
        end else begin
            wr_lane_s = {NBYTES{1'b0}};
        end
    end

    // Memory array: byte-lane writes, deliberately without reset.
    always_ff @(posedge PortAClk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_lane_s[i]) begin
                mem_q[wr_addr_s][i*BYTEWIDTH +: BYTEWIDTH] <= wr_data_s[i*BYTEWIDTH +: BYTEWIDTH];
            end
        end
    end

    // First output stage; the read sees the pre-write word, so write-first merges.
    always_ff @(posedge PortAClk) begin
        if (PortARst) begin
            dout1_q  <= {DATAWIDTH{1'b0}};
            valid1_q <= 1'b0;
        end else begin
            valid1_q <= fire_s;
            if (fire_s) begin
                if (is_write_s && (WRITEMODE == 32'd0)) begin
                    dout1_q <= lane_merge(mem_q[PortAAddr], PortADataIn, PortAWriteEnable);
                end else begin
                    dout1_q <= mem_q[PortAAddr];
                end
            end
        end
    end

    generate
        if (OUTREG != 0) begin : g_outreg
            logic [DATAWIDTH-1:0] dout2_q;
            logic                 valid2_q;

            // Optional second stage; holds its word when no new data arrives.
            always_ff @(posedge PortAClk) begin
                if (PortARst) begin
                    dout2_q  <= {DATAWIDTH{1'b0}};
                    valid2_q <= 1'b0;
                end else begin
                    valid2_q <= valid1_q;
                    if (valid1_q) begin
                        dout2_q <= dout1_q;
                    end
                end
            end

            assign PortADataOut   = dout2_q;
            assign PortADataValid = valid2_q;
        end else begin : g_noreg
            assign PortADataOut   = dout1_q;
            assign PortADataValid = valid1_q;
        end
    endgenerate

    assign InitBusy = init_busy_q;

endmodule
